// File: rtl/imem_pkg.sv
// ----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the loadable instruction memory:
//   - default width constants (address, opcode, register, immediate, boot size)
//   - FSM state enum {INIT, READY}
//   - boot_word(): the built-in boot image entry for a given address
// ----------------------------------------------------------------------------
package imem_pkg;

    localparam int IMEM_ADDR_W = 6;
    localparam int IMEM_OP_W   = 3;
    localparam int IMEM_REG_W  = 4;
    localparam int IMEM_IMM_W  = 16;
    localparam int IMEM_BOOT_N = 5;

    // Widest instruction the helper below can build; callers slice it down.
    localparam int IMEM_BOOT_MAX_W = 64;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } imem_state_t;

    // Boot image entry i: {op = 0, reg = i[reg_w-1:0], imm = i zero-extended}
    // for i < boot_n, all-zero otherwise. Packing is {op, reg, imm} MSB..LSB,
    // so the register field sits immediately above the immediate.
    function automatic logic [IMEM_BOOT_MAX_W-1:0] boot_word(
        input int unsigned i,
        input int unsigned reg_w  = IMEM_REG_W,
        input int unsigned imm_w  = IMEM_IMM_W,
        input int unsigned boot_n = IMEM_BOOT_N
    );
        logic [IMEM_BOOT_MAX_W-1:0] idx;
        logic [IMEM_BOOT_MAX_W-1:0] reg_mask;
        logic [IMEM_BOOT_MAX_W-1:0] imm_mask;
        idx      = IMEM_BOOT_MAX_W'(i);
        reg_mask = (IMEM_BOOT_MAX_W'(1) << reg_w) - IMEM_BOOT_MAX_W'(1);
        imm_mask = (IMEM_BOOT_MAX_W'(1) << imm_w) - IMEM_BOOT_MAX_W'(1);
        if (i >= boot_n) begin
            return '0;
        end
        return ((idx & reg_mask) << imm_w) | (idx & imm_mask);
    endfunction

endpackage : imem_pkg

// File: rtl/imem_array.sv
// ----------------------------------------------------------------------------
// imem_array
// DEPTH x DATA_W storage with one write port and one registered read port.
// Optional macro: IMEM_WR_BYPASS_EN
//   defined   -> same-address read/write in one cycle returns wdata (write-first)
//   undefined -> same case returns the previously stored word (read-first);
//                the write lands either way.
// Ports:
//   clk    in  clock
//   srst   in  synchronous active-high reset (clears the read register only)
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   re     in  read enable; rdata updates only when set, otherwise holds
//   raddr  in  read address
//   rdata  out registered read data
// ----------------------------------------------------------------------------
module imem_array #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 23
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage write kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register: reset to zero, loads only on a read, holds otherwise.
    always_ff @(posedge clk) begin
        if (srst) begin
            rdata_q <= '0;
        end else if (re) begin
`ifdef IMEM_WR_BYPASS_EN
            if (we && (waddr == raddr)) begin
                rdata_q <= wdata;
            end else begin
                rdata_q <= mem[raddr];
            end
`else
            rdata_q <= mem[raddr];
`endif
        end
    end

    assign rdata = rdata_q;

endmodule : imem_array

// File: rtl/instr_mem.sv
// ----------------------------------------------------------------------------
// instr_mem
// Loadable instruction memory for the fetch stage. After reset it walks the
// whole array writing the built-in boot image (INIT), then serves 1-cycle
// registered fetches and program-load writes (READY).
// Optional macro: IMEM_WR_BYPASS_EN (write-first on same-address read/write;
// read-first when undefined). Handled inside imem_array.
// Ports:
//   clk       in  clock, rising edge
//   reset     in  synchronous active-high reset; restarts the boot walk
//   ready     out high once the boot image is written
//   rd_req    in  fetch request (honoured only when ready)
//   rd_addr   in  fetch address
//   rd_valid  out code holds data for the previous cycle's request
//   code      out fetched word {op, reg, imm}
//   code_op   out opcode field of code
//   code_reg  out register field of code
//   code_imm  out immediate field of code
//   ld_en     in  program-load write enable (honoured only when ready)
//   ld_addr   in  load address
//   ld_data   in  load data
// ----------------------------------------------------------------------------
module instr_mem
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int OP_W   = IMEM_OP_W,
    parameter int REG_W  = IMEM_REG_W,
    parameter int IMM_W  = IMEM_IMM_W,
    parameter int BOOT_N = IMEM_BOOT_N,
    localparam int INSTR_W = OP_W + REG_W + IMM_W
) (
    input  logic               clk,
    input  logic               reset,
    output logic               ready,
    input  logic               rd_req,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic               rd_valid,
    output logic [INSTR_W-1:0] code,
    output logic [OP_W-1:0]    code_op,
    output logic [REG_W-1:0]   code_reg,
    output logic [IMM_W-1:0]   code_imm,
    input  logic               ld_en,
    input  logic [ADDR_W-1:0]  ld_addr,
    input  logic [INSTR_W-1:0] ld_data
);

    imem_state_t       state_q, state_d;
    logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
    logic              ready_q, ready_d;
    logic              rd_valid_q, rd_valid_d;

    logic                       mem_we;
    logic [ADDR_W-1:0]          mem_waddr;
    logic [INSTR_W-1:0]         mem_wdata;
    logic                       mem_re;
    logic [IMEM_BOOT_MAX_W-1:0] boot_full;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        ready_d    = ready_q;
        rd_valid_d = ready_q & rd_req;
        if (state_q == INIT) begin
            init_ptr_d = init_ptr_q + ADDR_W'(1);
            // Last boot word is being written this cycle.
            if (init_ptr_q == '1) begin
                state_d = READY;
                ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT;
            init_ptr_q <= '0;
            ready_q    <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            ready_q    <= ready_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // -------------------------------------------------- write-source mux
    assign boot_full = boot_word(int'(init_ptr_q), REG_W, IMM_W, BOOT_N);

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ld_addr;
        mem_wdata = ld_data;
        if (!reset) begin
            if (state_q == INIT) begin
                mem_we    = 1'b1;
                mem_waddr = init_ptr_q;
                mem_wdata = boot_full[INSTR_W-1:0];
            end else begin
                mem_we    = ld_en;
            end
        end
    end

    assign mem_re = ready_q & rd_req & ~reset;

    imem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (INSTR_W)
    ) u_array (
        .clk   (clk),
        .srst  (reset),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (rd_addr),
        .rdata (code)
    );

    // ----------------------------------------------------------- outputs
    assign ready    = ready_q;
    assign rd_valid = rd_valid_q;
    assign code_op  = code[INSTR_W-1 -: OP_W];
    assign code_reg = code[IMM_W +: REG_W];
    assign code_imm = code[IMM_W-1:0];

endmodule : instr_mem

// File: tb/tb_instr_mem.sv
// ----------------------------------------------------------------------------
// tb_instr_mem
// Self-checking bench for instr_mem at default parameters. Honours
// IMEM_WR_BYPASS_EN for the same-address read/write expectation.
// ----------------------------------------------------------------------------
module tb_instr_mem;

    localparam int ADDR_W  = 6;
    localparam int INSTR_W = 23;
    localparam int NVEC    = 10;

`ifdef IMEM_WR_BYPASS_EN
    localparam logic [INSTR_W-1:0] SAME_ADDR_EXP = 23'h000001;
`else
    localparam logic [INSTR_W-1:0] SAME_ADDR_EXP = 23'h000000;
`endif

    logic               clk;
    logic               reset;
    logic               ready;
    logic               rd_req;
    logic [ADDR_W-1:0]  rd_addr;
    logic               rd_valid;
    logic [INSTR_W-1:0] code;
    logic [2:0]         code_op;
    logic [3:0]         code_reg;
    logic [15:0]        code_imm;
    logic               ld_en;
    logic [ADDR_W-1:0]  ld_addr;
    logic [INSTR_W-1:0] ld_data;

    int errors = 0;
    int checks = 0;

    instr_mem dut (
        .clk      (clk),
        .reset    (reset),
        .ready    (ready),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .code     (code),
        .code_op  (code_op),
        .code_reg (code_reg),
        .code_imm (code_imm),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic               ld_en;
        logic [ADDR_W-1:0]  ld_addr;
        logic [INSTR_W-1:0] ld_data;
        logic               rd_req;
        logic [ADDR_W-1:0]  rd_addr;
        logic               exp_valid;
        logic [INSTR_W-1:0] exp_code;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Expected boot image: {op=0, reg=i, imm=i} for i<5 (reg at bit 16).
    function automatic logic [INSTR_W-1:0] boot_exp(input int i);
        logic [INSTR_W-1:0] w;
        w = '0;
        if (i < 5) w = (INSTR_W'(i) << 16) | INSTR_W'(i);
        return w;
    endfunction

    // Clock edges until ready rises, bounded; returns 0 on timeout.
    task automatic wait_ready(output int rise, output bit saw_valid);
        rise      = 0;
        saw_valid = 0;
        for (int c = 1; c <= 200; c++) begin
            step();
            if (rd_valid) saw_valid = 1;
            if (ready) begin
                rise = c;
                break;
            end
        end
    endtask

    initial begin
        int  rise;
        bit  saw_valid;

        // Directed vectors applied one per cycle after the boot image is read.
        vecs[0] = '{1'b0, 6'd0,  23'h000000, 1'b1, 6'd4,  1'b1, 23'h040004};
        vecs[1] = '{1'b1, 6'd10, 23'h5ABCDE, 1'b0, 6'd0,  1'b0, 23'h040004}; // load, code holds
        vecs[2] = '{1'b0, 6'd0,  23'h000000, 1'b1, 6'd10, 1'b1, 23'h5ABCDE}; // write visible next cycle
        vecs[3] = '{1'b1, 6'd7,  23'h000001, 1'b1, 6'd7,  1'b1, SAME_ADDR_EXP};
        vecs[4] = '{1'b0, 6'd0,  23'h000000, 1'b1, 6'd7,  1'b1, 23'h000001}; // write landed
        vecs[5] = '{1'b1, 6'd12, 23'h123456, 1'b1, 6'd1,  1'b1, 23'h010001}; // different addrs
        vecs[6] = '{1'b0, 6'd0,  23'h000000, 1'b1, 6'd12, 1'b1, 23'h123456};
        vecs[7] = '{1'b0, 6'd0,  23'h000000, 1'b0, 6'd12, 1'b0, 23'h123456}; // idle, hold
        vecs[8] = '{1'b1, 6'd63, 23'h7FFFFF, 1'b1, 6'd0,  1'b1, 23'h000000};
        vecs[9] = '{1'b0, 6'd0,  23'h000000, 1'b1, 6'd63, 1'b1, 23'h7FFFFF}; // top address

        reset = 1'b1; rd_req = 1'b0; rd_addr = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        step();
        step();
        chk("reset_ready",    32'(ready),    32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_code",     32'(code),     32'd0);

        // Release reset with load and fetch asserted throughout INIT.
        reset = 1'b0;
        ld_en = 1'b1; ld_addr = 6'd20; ld_data = 23'h7FFFFF;
        rd_req = 1'b1; rd_addr = 6'd20;
        wait_ready(rise, saw_valid);
        ld_en = 1'b0; rd_req = 1'b0;
        chk("ready_rise_cycle",   32'(rise),      32'd64);
        chk("init_no_rd_valid",   32'(saw_valid), 32'd0);
        chk("init_code_still_0",  32'(code),      32'd0);

        rd_req = 1'b1; rd_addr = 6'd3;
        step();
        chk("read3_code",  32'(code),     32'h030003);
        chk("read3_valid", 32'(rd_valid), 32'd1);

        // Back-to-back sweep of the whole boot image (addr 20 confirms the
        // INIT-time load was ignored).
        for (int i = 0; i < 64; i++) begin
            rd_addr = ADDR_W'(i);
            step();
            chk($sformatf("sweep_code[%0d]", i),  32'(code),     32'(boot_exp(i)));
            chk($sformatf("sweep_valid[%0d]", i), 32'(rd_valid), 32'd1);
        end

        for (int v = 0; v < NVEC; v++) begin
            ld_en   = vecs[v].ld_en;
            ld_addr = vecs[v].ld_addr;
            ld_data = vecs[v].ld_data;
            rd_req  = vecs[v].rd_req;
            rd_addr = vecs[v].rd_addr;
            step();
            chk($sformatf("vec%0d_valid", v), 32'(rd_valid), 32'(vecs[v].exp_valid));
            chk($sformatf("vec%0d_code", v),  32'(code),     32'(vecs[v].exp_code));
            chk($sformatf("vec%0d_op", v),    32'(code_op),  32'(vecs[v].exp_code[22:20]));
            chk($sformatf("vec%0d_reg", v),   32'(code_reg), 32'(vecs[v].exp_code[19:16]));
            chk($sformatf("vec%0d_imm", v),   32'(code_imm), 32'(vecs[v].exp_code[15:0]));
        end
        ld_en = 1'b0; rd_req = 1'b0;

        // Load addr 2, confirm, then reset while a read is requested.
        ld_en = 1'b1; ld_addr = 6'd2; ld_data = 23'h7FFFFF;
        step();
        ld_en = 1'b0; rd_req = 1'b1; rd_addr = 6'd2;
        step();
        chk("pre_reset_read2", 32'(code), 32'h7FFFFF);
        reset = 1'b1;
        step();
        chk("midreset_rd_valid", 32'(rd_valid), 32'd0);
        chk("midreset_ready",    32'(ready),    32'd0);
        chk("midreset_code",     32'(code),     32'd0);
        reset = 1'b0; rd_req = 1'b0;
        wait_ready(rise, saw_valid);
        chk("reinit_rise_cycle", 32'(rise),      32'd64);
        chk("reinit_no_valid",   32'(saw_valid), 32'd0);

        rd_req = 1'b1; rd_addr = 6'd2;
        step();
        chk("reinit_read2",  32'(code),     32'h020002);
        chk("reinit_valid2", 32'(rd_valid), 32'd1);
        rd_addr = 6'd10;
        step();
        chk("reinit_read10", 32'(code), 32'd0);
        rd_req = 1'b0;
        step();
        chk("final_idle_valid", 32'(rd_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_instr_mem
